// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request decode helpers for the data-memory LSU master.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Stores only exist as SB/SH/SW, so any store with the "unsigned" bit set is illegal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W:  bad = 1'b0;
            F3_BU, F3_HU:      bad = we;
            default:           bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = lsb[0];
            F3_W:        bad = (lsb != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f3_sel(input logic [2:0] f3);
        logic [3:0] sel;
        sel = 4'b0000;
        case (f3)
            F3_B, F3_BU: sel = 4'b0001;
            F3_H, F3_HU: sel = 4'b0011;
            F3_W:        sel = 4'b1111;
            default:     sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of lane-0 aligned read data according to the load width.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (funct3_i)
            F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
            F3_BU:   data_o = {24'd0, data_i[7:0]};
            F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
            F3_HU:   data_o = {16'd0, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_master.sv
// Initiator of the data-RAM port: one load/store at a time, registered response,
// extended load data or an error code back to the MEM stage.
module dmem_lsu_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 8,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_addr,
    output logic        o_addr_vld,
    output logic        o_wr_en,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_d_valid,
    output logic        o_rsp_vld,
    output logic [31:0] o_rsp_data,
    output logic [1:0]  o_rsp_err,
    output logic        o_stall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_err_q, rsp_err_d;

    logic               accept;
    logic [31:0]        ext_data;

    lsu_load_ext u_load_ext (
        .funct3_i (f3_q),
        .data_i   (i_rdata),
        .data_o   (ext_data)
    );

    // Request handshake: a request transfers in the cycle where i_req_vld and
    // o_req_rdy are both high; the MEM stage keeps it stable until then.
    assign o_req_rdy = (state_q == S_IDLE) && !rst;
    assign accept    = i_req_vld && o_req_rdy;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        we_d       = we_q;
        f3_d       = f3_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d = i_req_funct3;
                    we_d = i_req_we;
                    if (f3_illegal(i_req_we, i_req_funct3)) begin
                        rsp_err_d  = ERR_ILLEGAL;
                        rsp_data_d = 32'd0;
                        state_d    = S_DONE;
                    end else if (addr_misaligned(i_req_funct3, i_req_addr[1:0])) begin
                        rsp_err_d  = ERR_MISALIGN;
                        rsp_data_d = 32'd0;
                        state_d    = S_DONE;
                    end else begin
                        addr_d  = i_req_addr;
                        wdata_d = i_req_wdata;
                        sel_d   = f3_sel(i_req_funct3);
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                // A response on the final wait cycle still counts as success.
                if (i_d_valid) begin
                    rsp_data_d = we_q ? 32'd0 : ext_data;
                    rsp_err_d  = ERR_NONE;
                    state_d    = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = 32'd0;
                    rsp_err_d  = ERR_TIMEOUT;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                rsp_data_d = 32'd0;
                rsp_err_d  = ERR_NONE;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            sel_q      <= 4'd0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_sel      = sel_q;
    assign o_addr_vld = (state_q == S_REQ);
    assign o_wr_en    = (state_q == S_REQ) && we_q;
    assign o_rsp_vld  = (state_q == S_DONE);
    assign o_rsp_data = rsp_data_q;
    assign o_rsp_err  = rsp_err_q;
    assign o_stall    = (state_q != S_IDLE) || accept;

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Directed bench for dmem_lsu_master: loads, stores, error paths, timeout and mid-access reset.
module tb_dmem_lsu_master;

    logic        clk;
    logic        rst;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [31:0] o_addr;
    logic        o_addr_vld;
    logic        o_wr_en;
    logic [3:0]  o_sel;
    logic [31:0] o_wdata;
    logic [31:0] i_rdata;
    logic        i_d_valid;
    logic        o_rsp_vld;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_err;
    logic        o_stall;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    dmem_lsu_master #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_vld    (i_req_vld),
        .o_req_rdy    (o_req_rdy),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_addr       (o_addr),
        .o_addr_vld   (o_addr_vld),
        .o_wr_en      (o_wr_en),
        .o_sel        (o_sel),
        .o_wdata      (o_wdata),
        .i_rdata      (i_rdata),
        .i_d_valid    (i_d_valid),
        .o_rsp_vld    (o_rsp_vld),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_err    (o_rsp_err),
        .o_stall      (o_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag, input logic exp_rdy);
        chk({tag, ".addr"},     o_addr, 32'd0);
        chk({tag, ".wdata"},    o_wdata, 32'd0);
        chk({tag, ".sel"},      {28'd0, o_sel}, 32'd0);
        chk({tag, ".addr_vld"}, {31'd0, o_addr_vld}, 32'd0);
        chk({tag, ".wr_en"},    {31'd0, o_wr_en}, 32'd0);
        chk({tag, ".rsp_vld"},  {31'd0, o_rsp_vld}, 32'd0);
        chk({tag, ".rsp_data"}, o_rsp_data, 32'd0);
        chk({tag, ".rsp_err"},  {30'd0, o_rsp_err}, 32'd0);
        chk({tag, ".stall"},    {31'd0, o_stall}, 32'd0);
        chk({tag, ".rdy"},      {31'd0, o_req_rdy}, {31'd0, exp_rdy});
    endtask

    // Presents a request in cycle N; returns at the middle of cycle N+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
        @(negedge clk);
        i_req_vld    = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        #1;
        chk({tag, ".acc_rdy"},   {31'd0, o_req_rdy}, 32'd1);
        chk({tag, ".acc_stall"}, {31'd0, o_stall}, 32'd1);
        @(negedge clk);
        i_req_vld = 1'b0;
    endtask

    task automatic run_mem(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input logic [3:0] exp_sel, input logic [31:0] exp_data,
                           input string tag);
        issue(we, f3, addr, wd, tag);
        chk({tag, ".n1_addr_vld"}, {31'd0, o_addr_vld}, 32'd1);
        chk({tag, ".n1_wr_en"},    {31'd0, o_wr_en}, {31'd0, we});
        chk({tag, ".n1_addr"},     o_addr, addr);
        chk({tag, ".n1_sel"},      {28'd0, o_sel}, {28'd0, exp_sel});
        chk({tag, ".n1_wdata"},    o_wdata, wd);
        chk({tag, ".n1_rsp_vld"},  {31'd0, o_rsp_vld}, 32'd0);
        chk({tag, ".n1_rdy"},      {31'd0, o_req_rdy}, 32'd0);
        @(negedge clk);
        chk({tag, ".n2_addr_vld"}, {31'd0, o_addr_vld}, 32'd0);
        chk({tag, ".n2_wr_en"},    {31'd0, o_wr_en}, 32'd0);
        chk({tag, ".n2_stall"},    {31'd0, o_stall}, 32'd1);
        i_d_valid = 1'b1;
        i_rdata   = rdata;
        @(negedge clk);
        i_d_valid = 1'b0;
        i_rdata   = 32'd0;
        chk({tag, ".n3_rsp_vld"},  {31'd0, o_rsp_vld}, 32'd1);
        chk({tag, ".n3_rsp_data"}, o_rsp_data, exp_data);
        chk({tag, ".n3_rsp_err"},  {30'd0, o_rsp_err}, 32'd0);
        chk({tag, ".n3_stall"},    {31'd0, o_stall}, 32'd1);
        @(negedge clk);
        chk({tag, ".n4_rsp_vld"},  {31'd0, o_rsp_vld}, 32'd0);
        chk({tag, ".n4_rdy"},      {31'd0, o_req_rdy}, 32'd1);
        chk({tag, ".n4_stall"},    {31'd0, o_stall}, 32'd0);
    endtask

    task automatic run_err(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [1:0] exp_err, input string tag);
        issue(we, f3, addr, 32'hA5A5_5A5A, tag);
        chk({tag, ".n1_addr_vld"}, {31'd0, o_addr_vld}, 32'd0);
        chk({tag, ".n1_wr_en"},    {31'd0, o_wr_en}, 32'd0);
        chk({tag, ".n1_rsp_vld"},  {31'd0, o_rsp_vld}, 32'd1);
        chk({tag, ".n1_rsp_err"},  {30'd0, o_rsp_err}, {30'd0, exp_err});
        chk({tag, ".n1_rsp_data"}, o_rsp_data, 32'd0);
        chk({tag, ".n1_stall"},    {31'd0, o_stall}, 32'd1);
        @(negedge clk);
        chk({tag, ".n2_rsp_vld"},  {31'd0, o_rsp_vld}, 32'd0);
        chk({tag, ".n2_addr_vld"}, {31'd0, o_addr_vld}, 32'd0);
        chk({tag, ".n2_rdy"},      {31'd0, o_req_rdy}, 32'd1);
    endtask

    // With late set, i_d_valid arrives on the last allowed wait cycle.
    task automatic run_timeout(input logic late, input logic [31:0] rdata, input string tag);
        issue(1'b0, 3'b010, 32'h0000_0300, 32'd0, tag);
        chk({tag, ".n1_addr_vld"}, {31'd0, o_addr_vld}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("%s.wait%0d_rsp_vld", tag, k), {31'd0, o_rsp_vld}, 32'd0);
            chk($sformatf("%s.wait%0d_stall", tag, k), {31'd0, o_stall}, 32'd1);
            if (late && k == 7) begin
                i_d_valid = 1'b1;
                i_rdata   = rdata;
            end
        end
        @(negedge clk);
        i_d_valid = 1'b0;
        i_rdata   = 32'd0;
        chk({tag, ".done_rsp_vld"},  {31'd0, o_rsp_vld}, 32'd1);
        chk({tag, ".done_rsp_err"},  {30'd0, o_rsp_err}, late ? 32'd0 : 32'd2);
        chk({tag, ".done_rsp_data"}, o_rsp_data, late ? rdata : 32'd0);
        @(negedge clk);
        chk({tag, ".after_rsp_vld"}, {31'd0, o_rsp_vld}, 32'd0);
        chk({tag, ".after_rdy"},     {31'd0, o_req_rdy}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        i_req_vld    = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'd0;
        i_req_addr   = 32'd0;
        i_req_wdata  = 32'd0;
        i_rdata      = 32'd0;
        i_d_valid    = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_vals("in_reset", 1'b0);
        rst = 1'b0;
        #1;
        chk_reset_vals("post_reset", 1'b1);

        run_mem(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "lw");
        run_mem(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h0000_0080, 4'b0001, 32'hFFFF_FF80, "lb");
        run_mem(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h0000_0080, 4'b0001, 32'h0000_0080, "lbu");
        run_mem(1'b0, 3'b001, 32'h0000_0200, 32'd0, 32'hFFFF_8001, 4'b0011, 32'hFFFF_8001, "lh");
        run_mem(1'b0, 3'b101, 32'h0000_0200, 32'd0, 32'hFFFF_8001, 4'b0011, 32'h0000_8001, "lhu");
        run_mem(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 4'b0011, 32'd0, "sh");
        run_mem(1'b1, 3'b000, 32'h0000_0207, 32'h0000_00EE, 32'h0, 4'b0001, 32'd0, "sb");

        run_err(1'b1, 3'b010, 32'h0000_0101, 2'b01, "sw_misalign");
        run_err(1'b0, 3'b001, 32'h0000_0201, 2'b01, "lh_misalign");
        run_err(1'b0, 3'b011, 32'h0000_0100, 2'b11, "f3_011");
        run_err(1'b1, 3'b100, 32'h0000_0100, 2'b11, "store_f3_100");
        run_err(1'b0, 3'b111, 32'h0000_0001, 2'b11, "illegal_beats_misalign");

        run_timeout(1'b0, 32'd0, "timeout");

        // Spurious response while idle must not complete anything.
        @(negedge clk);
        i_d_valid = 1'b1;
        i_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        chk("spurious.rsp_vld1", {31'd0, o_rsp_vld}, 32'd0);
        chk("spurious.rdy1",     {31'd0, o_req_rdy}, 32'd1);
        @(negedge clk);
        i_d_valid = 1'b0;
        chk("spurious.rsp_vld2", {31'd0, o_rsp_vld}, 32'd0);
        chk("spurious.addr_vld", {31'd0, o_addr_vld}, 32'd0);

        run_timeout(1'b1, 32'h1357_9BDF, "late_ok");

        // Reset while waiting in RESP, response to the abandoned strobe arrives during reset.
        issue(1'b0, 3'b010, 32'h0000_0400, 32'd0, "rst_mid");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid", 1'b0);
        @(negedge clk);
        i_d_valid = 1'b1;
        i_rdata   = 32'h7777_7777;
        @(negedge clk);
        rst       = 1'b0;
        i_d_valid = 1'b0;
        i_rdata   = 32'd0;
        #1;
        chk_reset_vals("rst_release", 1'b1);
        run_mem(1'b0, 3'b010, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, "lw_after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
